// File: rtl/seg7_scan_blink.sv
// seg7_scan_blink: multi-digit hex 7-segment driver.
// Scans DIGITS digits in turn over a shared active-low segment bus, with per-digit
// blink, blank and decimal-point control. All outputs are registered.
module seg7_scan_blink #(
  parameter int DIGITS    = 4,
  parameter int SCAN_GAP  = 50000,
  parameter int BLINK_GAP = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int SW = (SCAN_GAP  > 1) ? $clog2(SCAN_GAP)  : 1;
  localparam int BW = (BLINK_GAP > 1) ? $clog2(BLINK_GAP) : 1;
  localparam int IW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

  // Terminal counts: counters are compared against these and cleared, never left to wrap.
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_GAP - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic              frame_tick_q, frame_tick_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic [3:0]        nibble;
  logic              dark;

  // Hex nibble to active-low gfedcba pattern.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0010000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      default: hex_decode = 7'b0001110;
    endcase
  endfunction

  // Scan counter and digit index; frozen while the display is disabled.
  always_comb begin
    scan_cnt_d   = scan_cnt_q;
    idx_d        = idx_q;
    frame_tick_d = 1'b0;
    if (en) begin
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d        = '0;
          frame_tick_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        scan_cnt_d = scan_cnt_q + SW'(1);
      end
    end
  end

  // Blink timebase; an empty mask parks it in the visible phase so the next blink starts lit.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (blink_mask == '0) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (en) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Next output pattern for the currently selected digit.
  always_comb begin
    nibble = value[{idx_q, 2'b00} +: 4];
    dark   = blank_mask[idx_q] | (blink_mask[idx_q] & phase_q);
    an_d   = '1;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (en) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = dark ? 7'h7F : hex_decode(nibble);
      dp_d  = ~(dp_in[idx_q] & ~dark);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
